// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared defaults and hazard-cause encoding for the ID-stage scoreboard
package hazard_pkg;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_WB_DIST  = 3;

    // Cause tags reported to the debug/perf counters, lowest priority first.
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        LOAD_USE = 2'd1,
        BRANCH   = 2'd2,
        JAL      = 2'd3
    } hazard_cause_e;

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one register's pending-write entry: set, kill and saturating countdown
module sb_entry
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 2,
    parameter int WB_DIST = DEF_WB_DIST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             set_load,
    input  logic             kill,
    output logic             pend,
    output logic             load,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            load <= 1'b0;
            cnt  <= '0;
        end else if (set) begin
            // A new write always wins, including over a kill aimed at the older one.
            pend <= 1'b1;
            load <= set_load;
            cnt  <= CNT_W'(WB_DIST);
        end else if (kill && pend && cnt == CNT_W'(WB_DIST)) begin
            // Entry still holds the value written last cycle, so it belongs to the squashed op.
            pend <= 1'b0;
            cnt  <= '0;
        end else if (pend) begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (cnt <= CNT_W'(1)) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage scoreboard raising stall for load-use, branch operands and jal bubbles
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WB_DIST   = DEF_WB_DIST,
    parameter int BR_FWD    = 0,
    parameter int JAL_STALL = 3,
    parameter int CNT_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   id_rs,
    input  logic [ADDR_W-1:0]   id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_branch,
    input  logic                id_jr,
    input  logic                id_jal,
    input  logic                id_wr_en,
    input  logic [ADDR_W-1:0]   id_wr_addr,
    input  logic                id_is_load,
    input  logic                kill_ex,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] pend_mask
);

    localparam int JW = (JAL_STALL < 2) ? 1 : $clog2(JAL_STALL + 1);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] load;
    logic [CNT_W-1:0]    cnt [NUM_REGS];

    logic [ADDR_W-1:0]   last_addr;
    logic                last_vld;
    logic [JW-1:0]       jal_cnt;

    logic rs_match, rt_match;
    logic load_use_hz, branch_hz, jal_hz;
    logic wr_issue;

    // Register 0 is hard-wired and never tracked.
    assign pend[0] = 1'b0;
    assign load[0] = 1'b0;
    assign cnt[0]  = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(
            .CNT_W   (CNT_W),
            .WB_DIST (WB_DIST)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .set      (wr_issue && id_wr_addr == ADDR_W'(r)),
            .set_load (id_is_load),
            .kill     (kill_ex && last_vld && last_addr == ADDR_W'(r)),
            .pend     (pend[r]),
            .load     (load[r]),
            .cnt      (cnt[r])
        );
    end

    always_comb begin
        rs_match    = id_use_rs && id_rs != '0 && pend[id_rs];
        rt_match    = id_use_rt && id_rt != '0 && pend[id_rt];
        // Load result is not available before it leaves EX, i.e. while the count is still full.
        load_use_hz = (rs_match && load[id_rs] && cnt[id_rs] == CNT_W'(WB_DIST)) ||
                      (rt_match && load[id_rt] && cnt[id_rt] == CNT_W'(WB_DIST));
        branch_hz   = (id_branch || id_jr) &&
                      ((rs_match && cnt[id_rs] > CNT_W'(BR_FWD)) ||
                       (rt_match && cnt[id_rt] > CNT_W'(BR_FWD)));
        jal_hz      = jal_cnt != '0;
        stall       = id_valid && (load_use_hz || branch_hz || jal_hz);
        issue       = id_valid && !stall;
        wr_issue    = issue && id_wr_en && id_wr_addr != '0;
        pend_mask   = pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld  <= 1'b0;
            last_addr <= '0;
        end else begin
            last_vld <= wr_issue;
            if (wr_issue) begin
                last_addr <= id_wr_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            jal_cnt <= '0;
        end else if (issue && id_jal) begin
            jal_cnt <= JW'(JAL_STALL);
        end else if (jal_cnt != '0) begin
            jal_cnt <= jal_cnt - JW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard bench for hazard_scoreboard (BR_FWD 0 and 2)
module tb_hazard_scoreboard;

    localparam logic [31:0] M8  = 32'h0000_0100;
    localparam logic [31:0] M9  = 32'h0000_0200;
    localparam logic [31:0] M10 = 32'h0000_0400;
    localparam logic [31:0] M31 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs, id_use_rt, id_branch, id_jr, id_jal;
    logic        id_wr_en, id_is_load, kill_ex;
    logic [4:0]  id_rs, id_rt, id_wr_addr;
    logic        stall_a, issue_a, stall_b, issue_b;
    logic [31:0] mask_a, mask_b;

    typedef struct {
        logic        sel;
        logic        stall;
        logic        issue;
        logic [31:0] mask;
    } exp_t;

    exp_t q[$];
    logic cur_sel;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.BR_FWD(0)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jr(id_jr),
        .id_jal(id_jal), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .kill_ex(kill_ex), .stall(stall_a), .issue(issue_a), .pend_mask(mask_a)
    );

    hazard_scoreboard #(.BR_FWD(2)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jr(id_jr),
        .id_jal(id_jal), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .kill_ex(kill_ex), .stall(stall_b), .issue(issue_b), .pend_mask(mask_b)
    );

    // Monitor: every cycle with a queued expectation, compare the selected DUT mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic        s, i;
            logic [31:0] m;
            e = q.pop_front();
            s = e.sel ? stall_b : stall_a;
            i = e.sel ? issue_b : issue_a;
            m = e.sel ? mask_b  : mask_a;
            checks += 3;
            if (s !== e.stall) begin
                failures++;
                $display("FAIL stall t=%0t dut=%0d got=%b exp=%b", $time, e.sel, s, e.stall);
            end
            if (i !== e.issue) begin
                failures++;
                $display("FAIL issue t=%0t dut=%0d got=%b exp=%b", $time, e.sel, i, e.issue);
            end
            if (m !== e.mask) begin
                failures++;
                $display("FAIL pend_mask t=%0t dut=%0d got=%h exp=%h", $time, e.sel, m, e.mask);
            end
        end
    end

    task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic ut, input logic br, input logic jr,
                       input logic jal, input logic wr, input logic [4:0] rd, input logic ld,
                       input logic kill, input logic r, input logic es, input logic [31:0] em);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = ur; id_use_rt = ut;
        id_branch = br; id_jr = jr; id_jal = jal; id_wr_en = wr; id_wr_addr = rd;
        id_is_load = ld; kill_ex = kill;
        e.sel = cur_sel; e.stall = es; e.issue = v & ~es; e.mask = em;
        q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] em);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, em);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic es, input logic [31:0] em);
        cyc(1, rs, rt, 1, 1, 0, 0, 0, 1, rd, 0, 0, 0, es, em);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] rs,
                      input logic es, input logic [31:0] em);
        cyc(1, rs, 0, 1, 0, 0, 0, 0, 1, rd, 1, 0, 0, es, em);
    endtask

    task automatic br(input logic [4:0] rs, input logic [4:0] rt, input logic is_jr,
                      input logic es, input logic [31:0] em);
        cyc(1, rs, rt, 1, ~is_jr, ~is_jr, is_jr, 0, 0, 0, 0, 0, 0, es, em);
    endtask

    task automatic jal_i(input logic link, input logic es, input logic [31:0] em);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, link, 5'd31, 0, 0, 0, es, em);
    endtask

    initial begin
        cur_sel = 0;
        rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_branch = 0; id_jr = 0; id_jal = 0; id_wr_en = 0; id_wr_addr = 0;
        id_is_load = 0; kill_ex = 0;
        repeat (2) @(posedge clk);

        idle(0);

        // load-use: one bubble, then ALU chain never stalls
        lw(8, 1, 0, 0);
        alu(9, 8, 2, 1, M8);
        alu(9, 8, 2, 0, M8);
        alu(10, 9, 3, 0, M8 | M9);
        idle(M9 | M10);
        idle(M9 | M10);
        idle(M10);
        idle(0);

        // branch on in-flight ALU result, no forwarding into ID
        alu(8, 1, 2, 0, 0);
        br(8, 0, 0, 1, M8);
        br(8, 0, 0, 1, M8);
        br(8, 0, 0, 1, M8);
        br(8, 0, 0, 0, 0);
        idle(0);

        // same on the BR_FWD=2 instance
        cur_sel = 1;
        alu(8, 1, 2, 0, 0);
        br(8, 0, 0, 1, M8);
        br(8, 0, 0, 0, M8);
        idle(M8);
        idle(0);
        cur_sel = 0;

        // jal window without link write
        jal_i(0, 0, 0);
        alu(9, 1, 2, 1, 0);
        alu(9, 1, 2, 1, 0);
        alu(9, 1, 2, 1, 0);
        alu(9, 1, 2, 0, 0);
        idle(M9);
        idle(M9);
        idle(M9);
        idle(0);

        // jal with link, reset in the second bubble cycle
        jal_i(1, 0, 0);
        alu(9, 1, 2, 1, M31);
        cyc(1, 1, 2, 1, 1, 0, 0, 0, 1, 9, 0, 0, 1, 1, M31);
        alu(9, 1, 2, 0, 0);
        idle(M9);
        idle(M9);
        idle(M9);
        idle(0);

        // WAW: jr tracks the younger write to $8
        alu(8, 1, 2, 0, 0);
        alu(8, 3, 4, 0, M8);
        br(8, 0, 1, 1, M8);
        br(8, 0, 1, 1, M8);
        br(8, 0, 1, 1, M8);
        br(8, 0, 1, 0, 0);
        idle(0);

        // kill of a load clears its entry
        lw(8, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, M8);
        alu(9, 8, 2, 0, 0);
        idle(M9);
        idle(M9);
        idle(M9);
        idle(0);

        // kill coinciding with a new write to $8 leaves the new entry
        lw(8, 1, 0, 0);
        cyc(1, 1, 2, 1, 1, 0, 0, 0, 1, 8, 0, 1, 0, 0, M8);
        alu(9, 8, 2, 0, M8);
        idle(M8 | M9);
        idle(M8 | M9);
        idle(M9);
        idle(0);

        // register 0 is never tracked
        alu(0, 1, 2, 0, 0);
        lw(0, 1, 0, 0);
        br(0, 0, 0, 0, 0);
        idle(0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
